// File: rtl/bf_fetch_unit_pkg.sv
// Opcode constants and fetch-state encoding for the BF fetch unit.
// The execute stage imports the same package, so both sides decode identically.
package bf_fetch_unit_pkg;

   localparam logic [3:0] OP_HALT       = 4'd0;
   localparam logic [3:0] OP_INC        = 4'd1;
   localparam logic [3:0] OP_DEC        = 4'd2;
   localparam logic [3:0] OP_RIGHT      = 4'd3;
   localparam logic [3:0] OP_LEFT       = 4'd4;
   localparam logic [3:0] OP_OUT        = 4'd5;
   localparam logic [3:0] OP_IN         = 4'd6;
   localparam logic [3:0] OP_LOOP_START = 4'd7;
   localparam logic [3:0] OP_LOOP_END   = 4'd8;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_SKIP,
      ST_HALTED,
      ST_ERROR
   } fetch_state_e;

endpackage

// File: rtl/bf_fetch_unit_loop_stack.sv
// Return-address LIFO for '[' positions; synchronous active-low reset to empty.
// Simultaneous push and pop never occur, so push takes priority if both are asserted.
module bf_loop_stack #(
   parameter int ADDR_WIDTH  = 8,
   parameter int STACK_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] push_data,
   output logic [ADDR_WIDTH-1:0] top,
   output logic                  full,
   output logic                  empty
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;

   logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
   logic [SP_W-1:0]       sp_q, sp_d, sp_m1;

   assign sp_m1 = sp_q - SP_W'(1);
   assign full  = (sp_q == SP_W'(STACK_DEPTH));
   assign empty = (sp_q == '0);
   assign top   = mem_q[sp_m1[IDX_W-1:0]];

   always_comb begin
      sp_d = sp_q;
      if (push && !full) begin
         sp_d = sp_q + SP_W'(1);
      end else if (pop && !empty) begin
         sp_d = sp_m1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry storage carries no reset; the stack pointer alone defines validity.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[sp_q[IDX_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/bf_fetch_unit.sv
// BF fetch/control-flow stage: PC, bracket resolution via loop stack and skip scanner.
// Define BF_FETCH_PERF_EN to add the saturating perf_cycles/perf_retired counters.
import bf_fetch_unit_pkg::*;

module bf_fetch_unit #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 4,
   parameter int STACK_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   input  logic                  exec_ready,
   input  logic                  exec_idle,
   input  logic                  cell_zero,
   output logic                  halted,
   output logic                  error
`ifdef BF_FETCH_PERF_EN
   ,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_retired
`endif
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH:0]   skip_q, skip_d;
   logic                  push, pop, stk_full, stk_empty;
   logic [ADDR_WIDTH-1:0] stk_top;
   logic                  valid, resolved, at_last;
   logic                  is_halt, is_open, is_close;

   assign at_last  = (pc_q == '1);
   assign is_halt  = (rom_data == DATA_WIDTH'(OP_HALT));
   assign is_open  = (rom_data == DATA_WIDTH'(OP_LOOP_START));
   assign is_close = (rom_data == DATA_WIDTH'(OP_LOOP_END));

   bf_loop_stack #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STACK_DEPTH(STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .pop      (pop),
      .push_data(pc_q),
      .top      (stk_top),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      skip_d   = skip_q;
      push     = 1'b0;
      pop      = 1'b0;
      valid    = 1'b0;
      resolved = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (is_halt) begin
               state_d = ST_HALTED;
            end else if (is_open) begin
               if (exec_idle) begin
                  if (!cell_zero) begin
                     if (stk_full) begin
                        state_d = ST_ERROR;
                     end else begin
                        push     = 1'b1;
                        resolved = 1'b1;
                        if (at_last) state_d = ST_HALTED;
                        else         pc_d    = pc_q + ADDR_WIDTH'(1);
                     end
                  end else begin
                     // A '[' on the last word can never find its match.
                     if (at_last) begin
                        state_d = ST_ERROR;
                     end else begin
                        resolved = 1'b1;
                        skip_d   = (ADDR_WIDTH+1)'(1);
                        pc_d     = pc_q + ADDR_WIDTH'(1);
                        state_d  = ST_SKIP;
                     end
                  end
               end
            end else if (is_close) begin
               if (exec_idle) begin
                  if (stk_empty) begin
                     state_d = ST_ERROR;
                  end else if (cell_zero) begin
                     pop      = 1'b1;
                     resolved = 1'b1;
                     if (at_last) state_d = ST_HALTED;
                     else         pc_d    = pc_q + ADDR_WIDTH'(1);
                  end else begin
                     resolved = 1'b1;
                     pc_d     = stk_top + ADDR_WIDTH'(1);
                  end
               end
            end else begin
               valid = 1'b1;
               if (exec_ready) begin
                  if (at_last) state_d = ST_HALTED;
                  else         pc_d    = pc_q + ADDR_WIDTH'(1);
               end
            end
         end
         ST_SKIP: begin
            if (is_close && skip_q == (ADDR_WIDTH+1)'(1)) begin
               resolved = 1'b1;
               skip_d   = '0;
               if (at_last) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_q + ADDR_WIDTH'(1);
                  state_d = ST_RUN;
               end
            end else begin
               if (is_open)       skip_d = skip_q + (ADDR_WIDTH+1)'(1);
               else if (is_close) skip_d = skip_q - (ADDR_WIDTH+1)'(1);
               if (at_last) state_d = ST_ERROR;
               else         pc_d    = pc_q + ADDR_WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         skip_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         skip_q  <= skip_d;
      end
   end

   // A HALT under the PC reports completion in the same cycle it is seen.
   assign rom_address = pc_q;
   assign instr       = rom_data;
   assign instr_valid = reset_n & valid;
   assign halted      = reset_n & ((state_q == ST_HALTED) || (state_q == ST_RUN && is_halt));
   assign error       = reset_n & (state_q == ST_ERROR);

`ifdef BF_FETCH_PERF_EN
   logic [31:0] perf_cycles_q, perf_retired_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_cycles_q  <= '0;
         perf_retired_q <= '0;
      end else begin
         if ((state_q == ST_RUN || state_q == ST_SKIP) && perf_cycles_q != '1)
            perf_cycles_q <= perf_cycles_q + 32'd1;
         if (((valid && exec_ready) || resolved) && perf_retired_q != '1)
            perf_retired_q <= perf_retired_q + 32'd1;
      end
   end

   assign perf_cycles  = perf_cycles_q;
   assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_bf_fetch_unit.sv
// Directed bench for bf_fetch_unit: straight-line issue, stalls, loops, skip, faults, reset.
module tb_bf_fetch_unit;
   import bf_fetch_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n, exec_ready, exec_idle, cell_zero;
   logic [7:0] rom_address;
   logic [3:0] rom_data, instr;
   logic       instr_valid, halted, error;
   logic [3:0] rom [256];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;
   assign rom_data = rom[rom_address];

   bf_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .STACK_DEPTH(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rom_address(rom_address),
      .rom_data   (rom_data),
      .instr      (instr),
      .instr_valid(instr_valid),
      .exec_ready (exec_ready),
      .exec_idle  (exec_idle),
      .cell_zero  (cell_zero),
      .halted     (halted),
      .error      (error)
   );

   task automatic fill(input logic [3:0] v);
      for (int i = 0; i < 256; i++) rom[i] = v;
   endtask

   // Leaves the bench just after the negedge following a reset edge, reset_n still low.
   task automatic do_reset();
      reset_n = 1'b0; exec_ready = 1'b1; exec_idle = 1'b1; cell_zero = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      fill(OP_INC);
      do_reset();
      checks++; if (rom_address !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_address); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
   endtask

   task automatic test_basic();
      int exp_op [4] = '{1, 1, 3, 5};
      fill(OP_HALT);
      rom[0] = OP_INC; rom[1] = OP_INC; rom[2] = OP_RIGHT; rom[3] = OP_OUT;
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (rom_address !== 8'(c)) begin errors++; $display("FAIL basic_addr c%0d got %0d want %0d", c, rom_address, c); end
         checks++; if (instr !== 4'(exp_op[c]) || instr_valid !== 1'b1) begin errors++; $display("FAIL basic_issue c%0d got op %0d v%b want op %0d v1", c, instr, instr_valid, exp_op[c]); end
         @(negedge clk);
      end
      #1;
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_halt got h%b v%b want h1 v0", halted, instr_valid); end
      @(negedge clk); @(negedge clk); #1;
      checks++; if (rom_address !== 8'd4 || halted !== 1'b1) begin errors++; $display("FAIL basic_stuck got addr %0d h%b want 4 h1", rom_address, halted); end
   endtask

   task automatic test_stall();
      int rdy  [6] = '{1, 0, 1, 1, 1, 1};
      int addr [6] = '{0, 1, 1, 2, 3, 4};
      int vld  [6] = '{1, 1, 1, 1, 1, 0};
      int exp_acc [4] = '{1, 1, 3, 5};
      int n_acc = 0;
      int acc_bad = 0;
      fill(OP_HALT);
      rom[0] = OP_INC; rom[1] = OP_INC; rom[2] = OP_RIGHT; rom[3] = OP_OUT;
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         exec_ready = rdy[c][0];
         #1;
         checks++; if (rom_address !== 8'(addr[c]) || instr_valid !== vld[c][0]) begin errors++; $display("FAIL stall_cycle c%0d got addr %0d v%b want addr %0d v%0d", c, rom_address, instr_valid, addr[c], vld[c]); end
         if (instr_valid && exec_ready) begin
            if (n_acc >= 4 || instr !== 4'(exp_acc[n_acc < 4 ? n_acc : 0])) acc_bad++;
            n_acc++;
         end
         @(negedge clk);
      end
      checks++; if (n_acc != 4 || acc_bad != 0) begin errors++; $display("FAIL stall_accepted got %0d ops (%0d wrong) want 4 (0 wrong)", n_acc, acc_bad); end
   endtask

   task automatic test_loop();
      int cz   [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      int addr [8] = '{0, 1, 2, 1, 2, 1, 2, 3};
      fill(OP_HALT);
      rom[0] = OP_LOOP_START; rom[1] = OP_INC; rom[2] = OP_LOOP_END;
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cell_zero = cz[c][0];
         #1;
         checks++; if (rom_address !== 8'(addr[c])) begin errors++; $display("FAIL loop_pc c%0d got %0d want %0d", c, rom_address, addr[c]); end
         if (addr[c] != 1) begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL loop_bracket_valid c%0d got %b want 0", c, instr_valid); end
         end
         if (c < 7) @(negedge clk);
      end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL loop_halted got %b want 1", halted); end
      checks++; if (dut.u_stack.empty !== 1'b1) begin errors++; $display("FAIL loop_stack_empty got %b want 1", dut.u_stack.empty); end
   endtask

   task automatic test_skip();
      int idle  [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
      int addr  [8] = '{0, 0, 1, 2, 3, 4, 5, 6};
      int depth [8] = '{0, 0, 1, 2, 2, 1, 1, 0};
      fill(OP_HALT);
      rom[0] = OP_LOOP_START; rom[1] = OP_LOOP_START; rom[2] = OP_INC;
      rom[3] = OP_LOOP_END;   rom[4] = OP_DEC;        rom[5] = OP_LOOP_END;
      do_reset();
      reset_n = 1'b1; cell_zero = 1'b1;
      for (int c = 0; c < 8; c++) begin
         exec_idle = idle[c][0];
         #1;
         checks++; if (rom_address !== 8'(addr[c]) || instr_valid !== 1'b0) begin errors++; $display("FAIL skip_addr c%0d got %0d v%b want %0d v0", c, rom_address, instr_valid, addr[c]); end
         checks++; if (dut.skip_q !== 9'(depth[c])) begin errors++; $display("FAIL skip_depth c%0d got %0d want %0d", c, dut.skip_q, depth[c]); end
         if (c < 7) @(negedge clk);
      end
      checks++; if (dut.state_q !== ST_RUN || halted !== 1'b1) begin errors++; $display("FAIL skip_resume got state %0d h%b want RUN h1", dut.state_q, halted); end
   endtask

   task automatic test_errors();
      // 17 nested '[' with a 16-deep stack
      fill(OP_INC);
      for (int i = 0; i < 17; i++) rom[i] = OP_LOOP_START;
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 17; c++) begin
         #1;
         checks++; if (rom_address !== 8'(c) || error !== 1'b0) begin errors++; $display("FAIL ovf_walk c%0d got addr %0d e%b want %0d e0", c, rom_address, error, c); end
         @(negedge clk);
      end
      #1;
      checks++; if (error !== 1'b1 || rom_address !== 8'd16 || instr_valid !== 1'b0) begin errors++; $display("FAIL ovf_error got e%b addr %0d v%b want e1 addr 16 v0", error, rom_address, instr_valid); end

      // stray ']'
      fill(OP_INC);
      rom[0] = OP_LOOP_END;
      do_reset();
      reset_n = 1'b1;
      #1;
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL stray_pre got %b want 0", error); end
      @(negedge clk); #1;
      checks++; if (error !== 1'b1 || rom_address !== 8'd0) begin errors++; $display("FAIL stray_error got e%b addr %0d want e1 addr 0", error, rom_address); end

      // unmatched '[' skipped to the end of ROM
      fill(OP_INC);
      rom[0] = OP_LOOP_START;
      do_reset();
      reset_n = 1'b1; cell_zero = 1'b1;
      for (int c = 0; c < 255; c++) @(negedge clk);
      #1;
      checks++; if (rom_address !== 8'd255 || error !== 1'b0) begin errors++; $display("FAIL unmatched_pre got addr %0d e%b want 255 e0", rom_address, error); end
      @(negedge clk); #1;
      checks++; if (rom_address !== 8'd255 || error !== 1'b1) begin errors++; $display("FAIL unmatched_error got addr %0d e%b want 255 e1", rom_address, error); end
   endtask

   task automatic test_end_of_rom();
      fill(OP_INC);
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 255; c++) @(negedge clk);
      #1;
      checks++; if (rom_address !== 8'd255 || instr_valid !== 1'b1) begin errors++; $display("FAIL eor_last got addr %0d v%b want 255 v1", rom_address, instr_valid); end
      @(negedge clk); #1;
      checks++; if (rom_address !== 8'd255 || halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL eor_halt got addr %0d h%b v%b want 255 h1 v0", rom_address, halted, instr_valid); end

      // backward ']' from the last address, then fall off the end
      fill(OP_INC);
      rom[254] = OP_LOOP_START; rom[255] = OP_LOOP_END;
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 256; c++) @(negedge clk);
      #1;
      checks++; if (rom_address !== 8'd255 || halted !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL eor_backjump got addr %0d h%b e%b want 255 h0 e0", rom_address, halted, error); end
      cell_zero = 1'b1;
      @(negedge clk); #1;
      checks++; if (rom_address !== 8'd255 || halted !== 1'b1) begin errors++; $display("FAIL eor_exit got addr %0d h%b want 255 h1", rom_address, halted); end
   endtask

   task automatic test_reset_mid();
      int cz [4] = '{0, 1, 1, 1};
      fill(OP_INC);
      for (int i = 0; i < 4; i++) rom[i] = OP_LOOP_START;
      do_reset();
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cell_zero = cz[c][0];
         @(negedge clk);
      end
      #1;
      checks++; if (dut.state_q !== ST_SKIP || dut.skip_q !== 9'd3 || dut.u_stack.empty !== 1'b0) begin errors++; $display("FAIL mid_setup got state %0d depth %0d empty %b want SKIP 3 0", dut.state_q, dut.skip_q, dut.u_stack.empty); end
      reset_n = 1'b0;
      @(negedge clk); #1;
      checks++; if (rom_address !== 8'd0 || error !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got addr %0d e%b v%b want 0 e0 v0", rom_address, error, instr_valid); end
      reset_n = 1'b1; cell_zero = 1'b0;
      #1;
      checks++; if (dut.state_q !== ST_RUN || dut.skip_q !== 9'd0 || dut.u_stack.empty !== 1'b1) begin errors++; $display("FAIL mid_state got state %0d depth %0d empty %b want RUN 0 1", dut.state_q, dut.skip_q, dut.u_stack.empty); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_loop();
      test_skip();
      test_errors();
      test_end_of_rom();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
